bus_rx_endpoint: RTL and testbench

- Receive-side terminal for the bus generator/arbiter. It sits on one terminal's `push`/`D_push` output of the bus, opposite the driver-side source FIFO that feeds the bus through `pndng`/`pop`/`D_pop`.
- Filters each delivered packet by destination ID and buffers accepted packets in a first-word-fall-through FIFO.
- Presents the packets to a local consumer over a valid/ready handshake, with overflow and misroute reporting.

---
 rtl/bus_rx_endpoint.sv | 176 +++++++++++++++++
 tb/tb_bus_rx_endpoint.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/bus_rx_endpoint.sv
// bus_rx_endpoint
// Receive-side terminal of the bus. It takes packets delivered on push/D_push,
// keeps those addressed to this terminal (unicast id or broadcast bdcst), and
// queues them in a first-word-fall-through FIFO for a local valid/ready consumer.
//
// Ports:
//   clk          clock, rising edge
//   reset        asynchronous active-low reset
//   push/D_push  packet delivered by the bus; destination ID in the top byte
//   out_valid    FIFO head valid
//   out_data     FIFO head packet
//   out_ready    consumer accepts head when out_valid is high
//   count        FIFO occupancy
//   full         count == depth
//   overflow     sticky: an addressed packet was lost on a full FIFO
//   clr_ovf      synchronous clear of overflow (a new drop wins)
//   drop_cnt     saturating count of overflow drops
//   misroute_cnt saturating count of packets not addressed to this terminal
//
// Build option: define BUS_RX_ERR_CNT_EN to include drop_cnt/misroute_cnt;
// without it both ports are tied to zero and the port list is unchanged.
module bus_rx_endpoint #(
  parameter int         pckg_sz = 16,
  parameter int         depth   = 8,
  parameter logic [7:0] id      = 8'd0,
  parameter logic [7:0] bdcst   = 8'hFF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [pckg_sz-1:0]     D_push,
  output logic                   out_valid,
  output logic [pckg_sz-1:0]     out_data,
  input  logic                   out_ready,
  output logic [$clog2(depth):0] count,
  output logic                   full,
  output logic                   overflow,
  input  logic                   clr_ovf,
  output logic [7:0]             drop_cnt,
  output logic [7:0]             misroute_cnt
);
  localparam int AW = $clog2(depth);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(depth);
  localparam logic [CW-1:0] ONE_C   = CW'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  typedef enum logic [1:0] {ST_EMPTY, ST_PART, ST_FULL} state_e;

  state_e             state_q;
  logic [pckg_sz-1:0] mem_q [depth];
  logic [AW-1:0]      wr_ptr_q, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      count_q, count_d;
  logic               out_valid_q, full_q, overflow_q;
  logic [pckg_sz-1:0] out_data_q;
  logic [7:0]         pkt_id;
  logic               hit, pop, wr, ovf_drop;

  assign pkt_id   = D_push[pckg_sz-1 -: 8];
  assign hit      = push && (pkt_id == id || pkt_id == bdcst);
  assign pop      = out_valid_q && out_ready;
  assign wr       = hit && (!full_q || pop);
  assign ovf_drop = hit && full_q && !pop;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (pop)
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    if (wr && !pop)
      count_d = count_q + ONE_C;
    else if (pop && !wr)
      count_d = count_q - ONE_C;
  end

  // Storage array, no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (wr)
      mem_q[wr_ptr_q] <= D_push;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      overflow_q  <= 1'b0;
    end else begin
      if (wr)
        wr_ptr_q <= wr_ptr_q + PTR_ONE;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      out_valid_q <= (count_d != '0);
      // Registered head: the next head is either the slot being written this
      // cycle (FIFO empty, or draining its last entry) or already in memory.
      // When the FIFO goes empty the last head value is held.
      if (count_d != '0) begin
        if (wr && (wr_ptr_q == rd_ptr_d))
          out_data_q <= D_push;
        else
          out_data_q <= mem_q[rd_ptr_d];
      end
      if (ovf_drop)
        overflow_q <= 1'b1;
      else if (clr_ovf)
        overflow_q <= 1'b0;
    end
  end

  // Occupancy FSM; tracks count_q so full is a clean register output.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_EMPTY;
      full_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (wr && !pop)
            state_q <= ST_PART;
        end
        ST_PART: begin
          if (wr && !pop && count_q == DEPTH_C - ONE_C) begin
            state_q <= ST_FULL;
            full_q  <= 1'b1;
          end else if (pop && !wr && count_q == ONE_C) begin
            state_q <= ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (pop && !wr) begin
            state_q <= ST_PART;
            full_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_EMPTY;
          full_q  <= 1'b0;
        end
      endcase
    end
  end

`ifdef BUS_RX_ERR_CNT_EN
  logic [7:0] drop_cnt_q, misroute_cnt_q;
  logic       misroute;

  assign misroute = push && !hit;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      drop_cnt_q     <= 8'd0;
      misroute_cnt_q <= 8'd0;
    end else begin
      if (ovf_drop && drop_cnt_q != 8'hFF)
        drop_cnt_q <= drop_cnt_q + 8'd1;
      if (misroute && misroute_cnt_q != 8'hFF)
        misroute_cnt_q <= misroute_cnt_q + 8'd1;
    end
  end

  assign drop_cnt     = drop_cnt_q;
  assign misroute_cnt = misroute_cnt_q;
`else
  assign drop_cnt     = 8'd0;
  assign misroute_cnt = 8'd0;
`endif

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign count     = count_q;
  assign full      = full_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_bus_rx_endpoint.sv
// Self-checking bench for bus_rx_endpoint (id=2, pckg_sz=16, depth=4).
// A vector table drives the main traffic; a small occupancy model plus a
// packet scoreboard supplies the expected head data and status every cycle.
module tb_bus_rx_endpoint;
  logic        clk;
  logic        reset;
  logic        push;
  logic [15:0] D_push;
  logic        out_valid;
  logic [15:0] out_data;
  logic        out_ready;
  logic [2:0]  count;
  logic        full;
  logic        overflow;
  logic        clr_ovf;
  logic [7:0]  drop_cnt;
  logic [7:0]  misroute_cnt;

  bus_rx_endpoint #(
    .pckg_sz(16),
    .depth  (4),
    .id     (8'h02),
    .bdcst  (8'hFF)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .push        (push),
    .D_push      (D_push),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_ready   (out_ready),
    .count       (count),
    .full        (full),
    .overflow    (overflow),
    .clr_ovf     (clr_ovf),
    .drop_cnt    (drop_cnt),
    .misroute_cnt(misroute_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        p;
    logic [15:0] d;
    logic        rdy;
    logic        clr;
    logic [2:0]  ecnt;
    logic        efull;
    logic        eovf;
  } vec_t;

  vec_t        vecs[$];
  logic [15:0] sb[$];
  int          m_count;
  logic        m_ovf;
  int          m_drop;
  int          m_mis;
  int          n_checks;
  int          n_fail;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic p, input logic [15:0] d, input logic rdy, input logic clr,
                     input logic [2:0] ecnt, input logic efull, input logic eovf);
    vec_t v;
    v.p = p; v.d = d; v.rdy = rdy; v.clr = clr;
    v.ecnt = ecnt; v.efull = efull; v.eovf = eovf;
    vecs.push_back(v);
  endtask

  // One bus cycle: drive inputs, check pre-edge state against the model at the
  // falling edge, then advance the model across the rising edge.
  task automatic cycle(input logic p, input logic [15:0] d, input logic rdy, input logic clr);
    logic mhit, mpop, mwr;
    push = p; D_push = d; out_ready = rdy; clr_ovf = clr;
    @(negedge clk);
    check("out_valid", 32'(out_valid), 32'(m_count != 0));
    check("count", 32'(count), 32'(m_count));
    check("full", 32'(full), 32'(m_count == 4));
    check("overflow", 32'(overflow), 32'(m_ovf));
    check("drop_cnt", 32'(drop_cnt), 32'(m_drop));
    check("misroute_cnt", 32'(misroute_cnt), 32'(m_mis));
    if (m_count != 0 && sb.size() != 0)
      check("out_data", 32'(out_data), 32'(sb[0]));
    mhit = p && (d[15:8] == 8'h02 || d[15:8] == 8'hFF);
    mpop = (m_count != 0) && rdy;
    mwr  = mhit && (m_count < 4 || mpop);
    @(posedge clk);
    #1;
    if (mpop && sb.size() != 0) void'(sb.pop_front());
    if (mwr) sb.push_back(d);
    m_count = m_count + (mwr ? 1 : 0) - (mpop ? 1 : 0);
    if (mhit && !mwr) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
`ifdef BUS_RX_ERR_CNT_EN
    if (mhit && !mwr && m_drop < 255) m_drop++;
    if (p && !mhit && m_mis < 255) m_mis++;
`endif
    $display("txn push=%b data=%h rdy=%b clr=%b -> count=%0d valid=%b head=%h ovf=%b",
             p, d, rdy, clr, count, out_valid, out_data, overflow);
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    m_count = 0; m_ovf = 1'b0; m_drop = 0; m_mis = 0;
    reset = 1'b0; push = 1'b0; D_push = 16'h0; out_ready = 1'b0; clr_ovf = 1'b0;

    // Single push, pop; misroute then broadcast
    add(1, 16'h02AB, 0, 0, 3'd1, 0, 0);
    add(0, 16'h0000, 1, 0, 3'd0, 0, 0);
    add(1, 16'h05CD, 0, 0, 3'd0, 0, 0);
    add(1, 16'hFF11, 0, 0, 3'd1, 0, 0);
    add(0, 16'h0000, 1, 0, 3'd0, 0, 0);
    // Fill, overflow, drain, clear
    add(1, 16'h0201, 0, 0, 3'd1, 0, 0);
    add(1, 16'h0202, 0, 0, 3'd2, 0, 0);
    add(1, 16'h0203, 0, 0, 3'd3, 0, 0);
    add(1, 16'h0204, 0, 0, 3'd4, 1, 0);
    add(1, 16'h0205, 0, 0, 3'd4, 1, 1);
    add(0, 16'h0000, 1, 0, 3'd3, 0, 1);
    add(0, 16'h0000, 1, 0, 3'd2, 0, 1);
    add(0, 16'h0000, 1, 0, 3'd1, 0, 1);
    add(0, 16'h0000, 1, 0, 3'd0, 0, 1);
    add(0, 16'h0000, 0, 1, 3'd0, 0, 0);
    // Full FIFO with simultaneous push and pop
    add(1, 16'h0201, 0, 0, 3'd1, 0, 0);
    add(1, 16'h0202, 0, 0, 3'd2, 0, 0);
    add(1, 16'h0203, 0, 0, 3'd3, 0, 0);
    add(1, 16'h0204, 0, 0, 3'd4, 1, 0);
    add(1, 16'h0209, 1, 0, 3'd4, 1, 0);
    add(0, 16'h0000, 1, 0, 3'd3, 0, 0);
    add(0, 16'h0000, 1, 0, 3'd2, 0, 0);
    add(0, 16'h0000, 1, 0, 3'd1, 0, 0);
    add(0, 16'h0000, 1, 0, 3'd0, 0, 0);
    // Push and pop together at count 1 (head replaced through the write path)
    add(1, 16'h0233, 0, 0, 3'd1, 0, 0);
    add(1, 16'hFF44, 1, 0, 3'd1, 0, 0);
    add(0, 16'h0000, 1, 0, 3'd0, 0, 0);
    // Overflow set beats clr_ovf in the same cycle
    add(1, 16'h0250, 0, 0, 3'd1, 0, 0);
    add(1, 16'h0251, 0, 0, 3'd2, 0, 0);
    add(1, 16'h0252, 0, 0, 3'd3, 0, 0);
    add(1, 16'h0253, 0, 0, 3'd4, 1, 0);
    add(1, 16'h0254, 0, 1, 3'd4, 1, 1);
    add(0, 16'h0000, 0, 1, 3'd4, 1, 0);
    add(0, 16'h0000, 1, 0, 3'd3, 0, 0);
    add(0, 16'h0000, 1, 0, 3'd2, 0, 0);
    add(0, 16'h0000, 1, 0, 3'd1, 0, 0);
    add(0, 16'h0000, 1, 0, 3'd0, 0, 0);

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_full", 32'(full), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_drop_cnt", 32'(drop_cnt), 32'd0);
    check("rst_misroute_cnt", 32'(misroute_cnt), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    @(posedge clk);
    #1;

    for (int i = 0; i < vecs.size(); i++) begin
      cycle(vecs[i].p, vecs[i].d, vecs[i].rdy, vecs[i].clr);
      check($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].ecnt));
      check($sformatf("vec%0d_full", i), 32'(full), 32'(vecs[i].efull));
      check($sformatf("vec%0d_overflow", i), 32'(overflow), 32'(vecs[i].eovf));
    end

    // Asynchronous reset with three packets stored
    cycle(1, 16'h0260, 0, 0);
    cycle(1, 16'h0261, 0, 0);
    cycle(1, 16'h0262, 0, 0);
    check("pre_reset_count", 32'(count), 32'd3);
    reset = 1'b0;
    #2;
    check("async_rst_out_valid", 32'(out_valid), 32'd0);
    check("async_rst_count", 32'(count), 32'd0);
    check("async_rst_full", 32'(full), 32'd0);
    sb.delete();
    m_count = 0; m_ovf = 1'b0; m_drop = 0; m_mis = 0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
    cycle(1, 16'h0277, 0, 0);
    check("post_rst_count", 32'(count), 32'd1);
    check("post_rst_head", 32'(out_data), 32'h0277);
    cycle(0, 16'h0000, 1, 0);
    check("post_rst_drained", 32'(count), 32'd0);
    cycle(0, 16'h0000, 0, 0);
    check("post_rst_valid", 32'(out_valid), 32'd0);
    check("post_rst_sb_empty", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
